// File: rtl/nbj_correction_sender.sv
// NBJ correction sender: builds correction words from resolved jumps, queues them, and
// delivers them to fetch over a drive/free handshake. Optional stats: NBJ_SENDER_STATS_EN.
module nbj_correction_sender #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_resolve_valid,
  output logic        o_resolve_ready,
  input  logic [2:0]  i_resolve_index_3,
  input  logic [31:0] i_pred_target_32,
  input  logic [31:0] i_actual_target_32,
  input  logic        i_last,
  input  logic        i_flush,
  output logic        o_drive_back,
  output logic [36:0] o_data_back_37,
  input  logic        i_free_back,
  output logic        o_busy
`ifdef NBJ_SENDER_STATS_EN
  ,
  output logic [15:0] o_mismatch_cnt_16,
  output logic [15:0] o_last_cnt_16
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_WAIT_FREE} state_t;

  state_t             state_q, state_d;
  logic [36:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [36:0]        data_q;
  logic               full, empty;
  logic               mismatch, enq, pop;
  logic [36:0]        word;

  // Extra wrap bit distinguishes full (wrap differs) from empty (pointers equal).
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign mismatch = (i_pred_target_32 != i_actual_target_32);
  assign enq      = i_resolve_valid && !full && (mismatch || i_last) && !i_flush;
  assign word     = {(mismatch ? i_last : 1'b1), mismatch, i_resolve_index_3, i_actual_target_32};

  assign o_resolve_ready = !full;
  assign o_data_back_37  = data_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, enq};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[PTR_W-1:0]] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst)      data_q <= '0;
    else if (pop) data_q <= mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A flush also suppresses the pop, so a head that would be latched this cycle is discarded.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (!empty && !i_flush) state_d = ST_DRIVE;
      ST_DRIVE:     state_d = ST_WAIT_FREE;
      ST_WAIT_FREE: if (i_free_back) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pop          = (state_q == ST_IDLE) && !empty && !i_flush;
    o_drive_back = (state_q == ST_DRIVE);
    o_busy       = !empty || (state_q != ST_IDLE);
  end

`ifdef NBJ_SENDER_STATS_EN
  logic [15:0] mis_cnt_q, last_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mis_cnt_q  <= '0;
      last_cnt_q <= '0;
    end else if (enq) begin
      if (word[35] && mis_cnt_q != 16'hFFFF)  mis_cnt_q  <= mis_cnt_q + 16'd1;
      if (word[36] && last_cnt_q != 16'hFFFF) last_cnt_q <= last_cnt_q + 16'd1;
    end
  end

  assign o_mismatch_cnt_16 = mis_cnt_q;
  assign o_last_cnt_16     = last_cnt_q;
`endif

endmodule

// File: tb/tb_nbj_correction_sender.sv
// Self-checking bench for nbj_correction_sender: directed plan steps plus random traffic
// against a queue-based model of the correction words.
module tb_nbj_correction_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_resolve_valid;
  logic        o_resolve_ready;
  logic [2:0]  i_resolve_index_3;
  logic [31:0] i_pred_target_32;
  logic [31:0] i_actual_target_32;
  logic        i_last;
  logic        i_flush;
  logic        o_drive_back;
  logic [36:0] o_data_back_37;
  logic        i_free_back;
  logic        o_busy;
`ifdef NBJ_SENDER_STATS_EN
  logic [15:0] o_mismatch_cnt_16;
  logic [15:0] o_last_cnt_16;
`endif

  always #5 clk = ~clk;

  nbj_correction_sender #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk                (clk),
    .rst                (rst),
    .i_resolve_valid    (i_resolve_valid),
    .o_resolve_ready    (o_resolve_ready),
    .i_resolve_index_3  (i_resolve_index_3),
    .i_pred_target_32   (i_pred_target_32),
    .i_actual_target_32 (i_actual_target_32),
    .i_last             (i_last),
    .i_flush            (i_flush),
    .o_drive_back       (o_drive_back),
    .o_data_back_37     (o_data_back_37),
    .i_free_back        (i_free_back),
    .o_busy             (o_busy)
`ifdef NBJ_SENDER_STATS_EN
    ,
    .o_mismatch_cnt_16  (o_mismatch_cnt_16),
    .o_last_cnt_16      (o_last_cnt_16)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  logic [36:0] exp_q [$];     // words accepted and not yet seen on the drive pulse
  logic        outst = 1'b0;  // a driven word is waiting for its free
  logic [36:0] held  = '0;
  int          mcnt  = 0;
  int          lcnt  = 0;
  logic        armed = 1'b0;
  logic        drv_s, ready_s, busy_s;
  logic [36:0] data_s;
  int          drives;

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs, check against the model, apply inputs, update model.
  // fmode: 0 = no free, 1 = free whenever a driven word is waiting, 2 = raw free pulse.
  task automatic cyc(input logic v, input logic [2:0] idx, input logic [31:0] pred,
                     input logic [31:0] act, input logic last, input logic flush,
                     input int fmode, input logic r);
    logic        fb;
    logic        mm;
    logic [36:0] w;
    drv_s   = o_drive_back;
    data_s  = o_data_back_37;
    ready_s = o_resolve_ready;
    busy_s  = o_busy;
    if (drv_s === 1'b1) begin
      drives++;
      chk("drive_while_outstanding", 37'(outst), 37'd0);
      chk("drive_has_word", 37'(exp_q.size() != 0), 37'd1);
      if (exp_q.size() != 0) chk("drive_data", data_s, exp_q.pop_front());
      outst = 1'b1;
      held  = data_s;
    end else if (outst) begin
      chk("hold_data", data_s, held);
    end
`ifdef NBJ_SENDER_STATS_EN
    if (armed) begin
      chk("mismatch_cnt", 37'(o_mismatch_cnt_16), 37'(mcnt));
      chk("last_cnt", 37'(o_last_cnt_16), 37'(lcnt));
    end
`endif
    fb = (fmode == 2) || (fmode == 1 && outst && drv_s !== 1'b1);
    if (fb && outst && drv_s !== 1'b1) outst = 1'b0;
    rst                = r;
    i_resolve_valid    = v;
    i_resolve_index_3  = idx;
    i_pred_target_32   = pred;
    i_actual_target_32 = act;
    i_last             = last;
    i_flush            = flush;
    i_free_back        = fb;
    if (r) begin
      exp_q.delete();
      outst = 1'b0;
      mcnt  = 0;
      lcnt  = 0;
    end else if (flush) begin
      exp_q.delete();
    end else if (v && ready_s === 1'b1) begin
      mm = (pred != act);
      if (mm || last) begin
        w = {(mm ? last : 1'b1), mm, idx, act};
        exp_q.push_back(w);
        if (w[35] && mcnt < 65535) mcnt++;
        if (w[36] && lcnt < 65535) lcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input int fmode);
    for (int k = 0; k < n; k++) cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, fmode, 1'b0);
  endtask

  initial begin
    logic [31:0] p;
    drives = 0;
    rst = 1'b1; i_resolve_valid = 1'b0; i_resolve_index_3 = '0; i_pred_target_32 = '0;
    i_actual_target_32 = '0; i_last = 1'b0; i_flush = 1'b0; i_free_back = 1'b0;
    @(posedge clk); #1;
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
    armed = 1'b1;
    idle(1, 0);
    chk("rst_drive", 37'(drv_s), 37'd0);
    chk("rst_data", data_s, 37'd0);
    chk("rst_ready", 37'(ready_s), 37'd1);
    chk("rst_busy", 37'(busy_s), 37'd0);

    // Single mismatch: drive two cycles after enqueue, held until free.
    cyc(1'b1, 3'd5, 32'h1000, 32'h2000, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 0);
    chk("lat_n1_drive", 37'(drv_s), 37'd0);
    idle(1, 0);
    chk("lat_n2_drive", 37'(drv_s), 37'd1);
    chk("mismatch_word", data_s, {1'b0, 1'b1, 3'd5, 32'h2000});
    idle(3, 0);
    chk("busy_waiting", 37'(busy_s), 37'd1);
    idle(1, 1);
    idle(1, 0);
    chk("busy_after_free", 37'(busy_s), 37'd0);

    // Match with last: last-type word.
    cyc(1'b1, 3'd2, 32'h40, 32'h40, 1'b1, 1'b0, 0, 1'b0);
    idle(2, 0);
    chk("last_drive", 37'(drv_s), 37'd1);
    chk("last_word", data_s, {1'b1, 1'b0, 3'd2, 32'h40});
    idle(1, 1);
    idle(1, 0);
    chk("last_busy_after_free", 37'(busy_s), 37'd0);

    // Match without last: dropped.
    cyc(1'b1, 3'd3, 32'h77, 32'h77, 1'b0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1, 0);
      chk("drop_no_drive", 37'(drv_s), 37'd0);
      chk("drop_not_busy", 37'(busy_s), 37'd0);
    end

    // Back-pressure: 1 in flight + 4 queued fills the FIFO.
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 3'(k), 32'h100 + 32'(k), 32'h900 + 32'(k), 1'b0, 1'b0, 0, 1'b0);
      chk("bp_ready_open", 37'(ready_s), 37'd1);
    end
    cyc(1'b1, 3'd7, 32'h1, 32'h2, 1'b0, 1'b0, 0, 1'b0);
    chk("bp_ready_full", 37'(ready_s), 37'd0);
    idle(3, 0);
    chk("bp_ready_still_full", 37'(ready_s), 37'd0);
    idle(1, 1);
    idle(1, 0);
    chk("bp_ready_before_pop", 37'(ready_s), 37'd0);
    idle(1, 0);
    chk("bp_ready_after_pop", 37'(ready_s), 37'd1);
    idle(30, 1);
    chk("bp_drained", 37'(exp_q.size()), 37'd0);
    chk("bp_idle_busy", 37'(busy_s), 37'd0);

    // Flush while the first word waits for its free; same-cycle enqueue is discarded.
    for (int k = 0; k < 3; k++)
      cyc(1'b1, 3'(k + 1), 32'h0, 32'h500 + 32'(k), 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 3'd6, 32'h0, 32'h600, 1'b1, 1'b1, 0, 1'b0);
    drives = 0;
    idle(8, 1);
    chk("flush_no_drive", 37'(drives), 37'd0);
    chk("flush_idle_busy", 37'(busy_s), 37'd0);
    chk("flush_ready", 37'(ready_s), 37'd1);

    // Reset during the wait for free.
    cyc(1'b1, 3'd4, 32'h10, 32'h20, 1'b1, 1'b0, 0, 1'b0);
    idle(2, 0);
    chk("pre_rst_drive", 37'(drv_s), 37'd1);
    idle(1, 0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b1);
    idle(1, 0);
    chk("post_rst_drive", 37'(drv_s), 37'd0);
    chk("post_rst_data", data_s, 37'd0);
    chk("post_rst_ready", 37'(ready_s), 37'd1);
    chk("post_rst_busy", 37'(busy_s), 37'd0);
    for (int k = 0; k < 4; k++) begin
      idle(1, 2);
      chk("stray_free_no_drive", 37'(drv_s), 37'd0);
    end

    // Random traffic against the queue model.
    for (int k = 0; k < 400; k++) begin
      p = $urandom;
      cyc(1'($urandom % 2), 3'($urandom), p, ($urandom % 2) ? p : $urandom,
          1'($urandom % 2), 1'b0, ($urandom % 3 == 0) ? 1 : 0, 1'b0);
    end
    idle(40, 1);
    chk("rand_drained", 37'(exp_q.size()), 37'd0);
    chk("rand_no_outstanding", 37'(outst), 37'd0);
    chk("rand_busy", 37'(busy_s), 37'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
